instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the control decoder: packs instruction commands (kind plus register and immediate fields) into 32-bit MIPS instruction words.
- Writes the words sequentially into the instruction-memory load port.
- Test-program loader for the single-cycle CPU. Sits between the bench/host command stream and instruction memory.
- Supports the opcode set the CPU decodes: R-type, addi, sltiu, beq, bne, lui, ori.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be word-aligned.
- DEPTH, 128, maximum number of words per load session.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  one-cycle pulse that opens a load session
- valid_i  in  1  command valid
- ready_o  out  1  command accepted when valid_i && ready_o
- kind_i  in  3  0=R, 1=ADDI, 2=SLTIU, 3=BEQ, 4=LUI, 5=ORI, 6=BNE, 7=END
- rs_i / rt_i / rd_i / shamt_i  in  5 each  register and shift fields
- funct_i  in  6  R-type function field
- imm_i  in  16  immediate or branch word offset
- imem_we_o  out  1  write request to instruction memory
- imem_ready_i  in  1  memory accepts the write this cycle
- imem_addr_o  out  32  write byte address
- imem_data_o  out  32  encoded instruction word
- count_o  out  $clog2(DEPTH)+1  words written this session
- done_o  out  1  session closed
- err_o  out  1  sticky error

Behaviour:
- Reset (rst_i=0, async): state IDLE. All outputs 0: ready_o, imem_we_o, imem_addr_o, imem_data_o, count_o, done_o, err_o. Any pending word is discarded.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: ready_o=0. start_i -> LOAD; address=BASE_ADDR; count_o, done_o, err_o cleared.
  - LOAD: ready_o = !pending || imem_ready_i. start_i is ignored.
  - DONE: done_o=1, ready_o=0. start_i -> LOAD, with the same clearing as from IDLE.
- Encoding:
  - R: {6'b000000, rs, rt, rd, shamt, funct}.
  - I-type: {opcode, rs, rt, imm}. Opcodes: ADDI 001000, SLTIU 001011, BEQ 000100, BNE 000101, LUI 001111, ORI 001101.
  - LUI forces the rs field to 0.
  - Unused fields of each kind are ignored.
- Accepted non-END command: the word is registered into the pending slot. imem_we_o=1 from the next cycle (latency 1).
  - imem_we_o, imem_addr_o and imem_data_o hold stable until imem_ready_i=1.
  - On that handshake: address += 4 and count_o += 1.
- Accept while a write completes in the same cycle: the slot is refilled with no bubble, giving one word per cycle throughput.
- END accepted: transition to DONE only after the pending write completes. ready_o=0 while draining.
- Capacity: a non-END command accepted when count_o plus pending equals DEPTH is dropped. err_o=1, state -> DONE after the drain. END at exactly DEPTH words is legal.
- Address never wraps within a session; the DEPTH bound guarantees this.
- start_i and END in the same cycle during LOAD: END is honoured, start_i is ignored.
- Reset mid-write: imem_we_o drops immediately (async); the partial session is lost.

Optional Feature:
- Macro: INSTR_ENC_FUNCT_CHECK_EN.
- Defined: an R-type command whose funct is not one of add 100000, sub 100010, and 100100, or 100101, slt 101010 is dropped (not written). err_o is set and the session continues.
- Undefined: funct passes through unchecked; err_o is raised only on overflow.

Decomposition:
- Shared package instr_pkg holds:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_SLTIU, OP_BEQ, OP_BNE, OP_LUI, OP_ORI);
  - the 3-bit kind enum and its codes;
  - funct constants.
- Both the CPU decoder and this block use instr_pkg.
- One combinational sub-module, instr_field_pack (kind plus fields -> 32-bit word), keeps the FSM and handshake logic separate from encoding.

Test Plan:
- start; ADDI rs=0 rt=1 imm=5; END -> one write: addr 0x0, data 0x20010005; then count_o=1, done_o=1, err_o=0.
- Back-to-back: R add (rs=1 rt=2 rd=3 funct=100000), LUI rt=4 imm=0x1234 with rs_i=7, ORI rs=4 rt=4 imm=0x5678, SLTIU rs=1 rt=5 imm=7 -> data 0x00221820, 0x3C041234, 0x34845678, 0x2C250007 at addresses 0x0/0x4/0x8/0xC, one per cycle.
- BEQ rs=1 rt=2 imm=0xFFFF, with imem_ready_i held 0 for 3 cycles -> data 0x1022FFFF held stable, ready_o=0 while the slot is full. Then BNE imm=3 -> 0x14220003 at 0x4.
- DEPTH=4: five non-END commands -> 4 writes, err_o=1, done_o=1. A new start_i clears err_o and count_o and restarts at BASE_ADDR.
- Assert rst_i=0 while imem_we_o=1 -> imem_we_o=0 in the same cycle, all outputs 0. After release, commands are ignored until start_i.
- With INSTR_ENC_FUNCT_CHECK_EN: R funct=000000, then ADDI -> R dropped, err_o=1, ADDI written at 0x0. Without the macro: R word 0x00000000-class written at 0x0, err_o=0.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared MIPS instruction constants used by both the control decoder and the instruction encoder.
// Holds the opcode and funct codes, the command-kind enum and the encoder FSM states.
package instr_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        KIND_R     = 3'd0,
        KIND_ADDI  = 3'd1,
        KIND_SLTIU = 3'd2,
        KIND_BEQ   = 3'd3,
        KIND_LUI   = 3'd4,
        KIND_ORI   = 3'd5,
        KIND_BNE   = 3'd6,
        KIND_END   = 3'd7
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } enc_state_e;

    // True for the R-type functions the single-cycle CPU actually executes.
    function automatic logic funct_is_legal(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT);
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: command kind plus register/immediate fields -> 32-bit MIPS word.
// END and any unknown kind produce an all-zero word; the caller never writes it.
module instr_field_pack (
    input  logic [2:0]  i_kind,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_shamt,
    input  logic [5:0]  i_funct,
    input  logic [15:0] i_imm,
    output logic [31:0] o_word
);
    import instr_pkg::*;

    always_comb begin
        o_word = 32'h0;
        case (kind_e'(i_kind))
            KIND_R:     o_word = {OP_RTYPE, i_rs, i_rt, i_rd, i_shamt, i_funct};
            KIND_ADDI:  o_word = {OP_ADDI,  i_rs, i_rt, i_imm};
            KIND_SLTIU: o_word = {OP_SLTIU, i_rs, i_rt, i_imm};
            KIND_BEQ:   o_word = {OP_BEQ,   i_rs, i_rt, i_imm};
            KIND_BNE:   o_word = {OP_BNE,   i_rs, i_rt, i_imm};
            // LUI has no source register; rs is forced to zero whatever the host sent.
            KIND_LUI:   o_word = {OP_LUI,   5'd0, i_rt, i_imm};
            KIND_ORI:   o_word = {OP_ORI,   i_rs, i_rt, i_imm};
            default:    o_word = 32'h0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Test-program loader: encodes host commands and writes them sequentially into instruction memory.
// Optional macro INSTR_ENC_FUNCT_CHECK_EN drops R-type commands with unsupported funct and flags err_o.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 128
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [2:0]               kind_i,
    input  logic [4:0]               rs_i,
    input  logic [4:0]               rt_i,
    input  logic [4:0]               rd_i,
    input  logic [4:0]               shamt_i,
    input  logic [5:0]               funct_i,
    input  logic [15:0]              imm_i,
    output logic                     imem_we_o,
    input  logic                     imem_ready_i,
    output logic [31:0]              imem_addr_o,
    output logic [31:0]              imem_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     done_o,
    output logic                     err_o
);
    import instr_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    enc_state_e  r_state;
    enc_state_e  w_state_next;
    logic        r_pending;
    logic        r_drain;
    logic        r_err;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [CW-1:0] r_count;

    logic [31:0] w_word;
    logic [CW:0] w_used;
    logic        w_wr_done;
    logic        w_accept;
    logic        w_is_end;
    logic        w_full;
    logic        w_funct_ok;
    logic        w_push;
    logic        w_close;
    logic        w_cmd_err;
    logic        w_can_finish;
    logic        w_start;

    instr_field_pack u_pack (
        .i_kind  (kind_i),
        .i_rs    (rs_i),
        .i_rt    (rt_i),
        .i_rd    (rd_i),
        .i_shamt (shamt_i),
        .i_funct (funct_i),
        .i_imm   (imm_i),
        .o_word  (w_word)
    );

    assign w_wr_done    = r_pending && imem_ready_i;
    assign ready_o      = (r_state == ST_LOAD) && !r_drain && (!r_pending || imem_ready_i);
    assign w_accept     = valid_i && ready_o;
    assign w_is_end     = (kind_e'(kind_i) == KIND_END);
    // Occupancy counts the pending word even if it completes this cycle: it is already committed.
    assign w_used       = {1'b0, r_count} + {{CW{1'b0}}, r_pending};
    assign w_full       = (w_used == (CW + 1)'(DEPTH));
    assign w_can_finish = !r_pending || imem_ready_i;
    assign w_start      = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));

`ifdef INSTR_ENC_FUNCT_CHECK_EN
    assign w_funct_ok = (kind_e'(kind_i) != KIND_R) || funct_is_legal(funct_i);
`else
    assign w_funct_ok = 1'b1;
`endif

    assign w_push    = w_accept && !w_is_end && !w_full && w_funct_ok;
    assign w_close   = w_accept && (w_is_end || w_full);
    assign w_cmd_err = w_accept && !w_is_end && (w_full || !w_funct_ok);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start_i) w_state_next = ST_LOAD;
            // Closing (END or overflow) waits until the last pending word has been taken.
            ST_LOAD: if ((r_drain || w_close) && w_can_finish) w_state_next = ST_DONE;
            ST_DONE: if (start_i) w_state_next = ST_LOAD;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pending <= 1'b0;
            r_drain   <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= 32'h0;
            r_data    <= 32'h0;
            r_count   <= '0;
        end else if (w_start) begin
            r_pending <= 1'b0;
            r_drain   <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= BASE_ADDR;
            r_count   <= '0;
        end else begin
            if (w_wr_done) begin
                r_addr  <= r_addr + 32'd4;
                r_count <= r_count + CW'(1);
            end
            // A refill in the same cycle as a completed write keeps the slot full with no bubble.
            if (w_push) begin
                r_pending <= 1'b1;
                r_data    <= w_word;
            end else if (w_wr_done) begin
                r_pending <= 1'b0;
            end
            if (w_cmd_err) begin
                r_err <= 1'b1;
            end
            if (w_close && !w_can_finish) begin
                r_drain <= 1'b1;
            end else if (w_state_next == ST_DONE) begin
                r_drain <= 1'b0;
            end
        end
    end

    assign imem_we_o   = r_pending;
    assign imem_addr_o = r_addr;
    assign imem_data_o = r_data;
    assign count_o     = r_count;
    assign done_o      = (r_state == ST_DONE);
    assign err_o       = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (DEPTH=4): table-driven encodings plus handshake corner sequences.
// Expected writes are queued on command acceptance and compared when the memory handshake occurs.
module tb_instr_encoder;
    import instr_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          start_i = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [2:0]    kind_i = 3'd0;
    logic [4:0]    rs_i = 5'd0;
    logic [4:0]    rt_i = 5'd0;
    logic [4:0]    rd_i = 5'd0;
    logic [4:0]    shamt_i = 5'd0;
    logic [5:0]    funct_i = 6'd0;
    logic [15:0]   imm_i = 16'd0;
    logic          imem_we_o;
    logic          imem_ready_i = 1'b1;
    logic [31:0]   imem_addr_o;
    logic [31:0]   imem_data_o;
    logic [CW-1:0] count_o;
    logic          done_o;
    logic          err_o;

    always #5 clk_i = ~clk_i;

    instr_encoder #(.BASE_ADDR(32'h0), .DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .kind_i       (kind_i),
        .rs_i         (rs_i),
        .rt_i         (rt_i),
        .rd_i         (rd_i),
        .shamt_i      (shamt_i),
        .funct_i      (funct_i),
        .imm_i        (imm_i),
        .imem_we_o    (imem_we_o),
        .imem_ready_i (imem_ready_i),
        .imem_addr_o  (imem_addr_o),
        .imem_data_o  (imem_data_o),
        .count_o      (count_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          wr_cycle[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cycle = 0;
    logic [31:0] exp_addr = 32'h0;
    vec_t        vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(posedge clk_i) cycle++;

    // Memory-side monitor: each completed handshake is one transaction.
    always @(negedge clk_i) begin
        if (rst_i && imem_we_o && imem_ready_i) begin
            wr_cycle.push_back(cycle);
            $display("write addr=0x%08h data=0x%08h", imem_addr_o, imem_data_o);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write",
                         imem_addr_o, imem_data_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", imem_addr_o, mon_e.addr);
                check("wr_data", imem_data_o, mon_e.data);
            end
        end
    end

    task automatic status(input string name, input int exp_count, input logic exp_done, input logic exp_err);
        check({name, "_count"}, 32'(count_o), 32'(exp_count));
        check({name, "_done"}, 32'(done_o), 32'(exp_done));
        check({name, "_err"}, 32'(err_o), 32'(exp_err));
    endtask

    task automatic start_session();
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i  = 1'b0;
        exp_addr = 32'h0;
        @(negedge clk_i);
        status("start", 0, 1'b0, 1'b0);
        @(posedge clk_i); #1;
    endtask

    task automatic send(input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] shamt, input logic [5:0] funct,
                        input logic [15:0] imm, input logic exp_write, input logic [31:0] exp_data);
        bit acc = 1'b0;
        kind_i = kind; rs_i = rs; rt_i = rt; rd_i = rd; shamt_i = shamt; funct_i = funct; imm_i = imm;
        valid_i = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk_i);
            if (ready_o) begin
                acc = 1'b1;
                if (exp_write) begin
                    exp_q.push_back('{addr: exp_addr, data: exp_data});
                    exp_addr += 32'd4;
                end
            end
            @(posedge clk_i); #1;
        end
        valid_i = 1'b0;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL accept_timeout: kind %0d not accepted in 20 cycles, expected acceptance", kind);
        end
    endtask

    task automatic send_end();
        send(KIND_END, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 1'b0, 32'h0);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_i);
            if (done_o) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done_timeout: done_o stayed 0 for 20 cycles, expected 1");
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(ready_o), 32'h0);
        check({tag, "_we"}, 32'(imem_we_o), 32'h0);
        check({tag, "_addr"}, imem_addr_o, 32'h0);
        check({tag, "_data"}, imem_data_o, 32'h0);
        status(tag, 0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded 100000 time units, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{KIND_ADDI,  5'd0, 5'd1, 5'd0, 5'd0, 6'd0,   16'h0005, 32'h2001_0005};
        vecs[1] = '{KIND_R,     5'd1, 5'd2, 5'd3, 5'd0, FN_ADD, 16'h0000, 32'h0022_1820};
        vecs[2] = '{KIND_LUI,   5'd7, 5'd4, 5'd0, 5'd0, 6'd0,   16'h1234, 32'h3C04_1234};
        vecs[3] = '{KIND_ORI,   5'd4, 5'd4, 5'd0, 5'd0, 6'd0,   16'h5678, 32'h3484_5678};
        vecs[4] = '{KIND_SLTIU, 5'd1, 5'd5, 5'd0, 5'd0, 6'd0,   16'h0007, 32'h2C25_0007};

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_reset_outputs("reset");
        @(posedge clk_i); #1;
        rst_i = 1'b1;

        // Single ADDI session.
        start_session();
        send(vecs[0].kind, vecs[0].rs, vecs[0].rt, vecs[0].rd, vecs[0].shamt,
             vecs[0].funct, vecs[0].imm, 1'b1, vecs[0].exp_data);
        send_end();
        wait_done();
        status("single", 1, 1'b1, 1'b0);

        // Back-to-back burst filling exactly DEPTH words, then a legal END.
        start_session();
        wr_cycle.delete();
        for (int i = 1; i < 5; i++) begin
            send(vecs[i].kind, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].shamt,
                 vecs[i].funct, vecs[i].imm, 1'b1, vecs[i].exp_data);
        end
        send_end();
        wait_done();
        status("burst", 4, 1'b1, 1'b0);
        check("burst_writes", 32'(wr_cycle.size()), 32'd4);
        if (wr_cycle.size() == 4) check("burst_span", 32'(wr_cycle[3] - wr_cycle[0]), 32'd3);

        // Back-pressure: the held word must stay stable while memory stalls.
        start_session();
        imem_ready_i = 1'b0;
        send(KIND_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 1'b1, 32'h1022_FFFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("stall_we", 32'(imem_we_o), 32'h1);
            check("stall_data", imem_data_o, 32'h1022_FFFF);
            check("stall_addr", imem_addr_o, 32'h0);
            check("stall_ready", 32'(ready_o), 32'h0);
        end
        @(posedge clk_i); #1;
        imem_ready_i = 1'b1;
        send(KIND_BNE, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0003, 1'b1, 32'h1422_0003);
        send_end();
        wait_done();
        status("stall", 2, 1'b1, 1'b0);

        // Overflow: the fifth word is dropped and closes the session with an error.
        start_session();
        for (int i = 0; i < 5; i++) begin
            send(KIND_ADDI, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'(i + 16),
                 (i < 4) ? 1'b1 : 1'b0, 32'h2001_0010 + 32'(i));
        end
        wait_done();
        status("overflow", 4, 1'b1, 1'b1);
        start_session();
        send(KIND_ADDI, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0077, 1'b1, 32'h2001_0077);
        send_end();
        wait_done();
        status("restart", 1, 1'b1, 1'b0);

        // R-type with funct 000000: dropped only when the funct check is built in.
        start_session();
`ifdef INSTR_ENC_FUNCT_CHECK_EN
        send(KIND_R, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 1'b0, 32'h0);
`else
        send(KIND_R, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 1'b1, 32'h0);
`endif
        send(KIND_ADDI, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0009, 1'b1, 32'h2001_0009);
        send_end();
        wait_done();
`ifdef INSTR_ENC_FUNCT_CHECK_EN
        status("funct", 1, 1'b1, 1'b1);
`else
        status("funct", 2, 1'b1, 1'b0);
`endif

        // Asynchronous reset while a write is pending.
        start_session();
        imem_ready_i = 1'b0;
        send(KIND_ADDI, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0042, 1'b1, 32'h2001_0042);
        #2;
        rst_i = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        exp_q.delete();
        @(posedge clk_i); #1;
        rst_i        = 1'b1;
        imem_ready_i = 1'b1;
        kind_i       = KIND_ADDI;
        imm_i        = 16'h0055;
        valid_i      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("idle_ready", 32'(ready_o), 32'h0);
            check("idle_we", 32'(imem_we_o), 32'h0);
        end
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
